// File: rtl/program_sequencer.sv
// Program sequencer: PC update, relative/absolute jumps,
// prioritized nested interrupts with a return stack.
module program_sequencer #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned NVEC       = 4,
   parameter int unsigned VEC_BASE   = 32'h0002,
   parameter int unsigned VEC_STRIDE = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             AluIn,
   input  logic                         absJmp,
   input  logic                         relJmp,
   input  logic                         stall,
   input  logic [NVEC-1:0]              intr,
   input  logic                         reti,
   output logic [WIDTH-1:0]             PC,
   output logic [WIDTH-1:0]             Nextpc,
   output logic [NVEC-1:0]              intrAck,
   output logic                         inIsr,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         stackErr
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(NVEC + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic [PW-1:0]    pri_q, pri_d;
   logic [NVEC-1:0]  ack_q, ack_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] stk_pc  [DEPTH];
   logic [PW-1:0]    stk_pri [DEPTH];

   logic             cand_vld;
   logic [PW-1:0]    cand;
   logic             accept;
   logic             push;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic [WIDTH-1:0] vec_addr;

   assign wr_idx   = AW'(lvl_q);
   assign rd_idx   = AW'(lvl_q - LW'(1));
   assign vec_addr = WIDTH'(VEC_BASE + 32'(cand) * VEC_STRIDE);

   // Lowest-numbered pending channel wins arbitration
   always_comb begin
      cand_vld = 1'b0;
      cand     = '0;
      for (int i = NVEC - 1; i >= 0; i--) begin
         if (intr[i]) begin
            cand_vld = 1'b1;
            cand     = PW'(i);
         end
      end
   end

   assign accept = cand_vld && (cand < pri_q) && (lvl_q < LW'(DEPTH));

   // Next-state selection in fixed action priority order
   always_comb begin
      pc_d  = pc_q;
      lvl_d = lvl_q;
      pri_d = pri_q;
      ack_d = '0;
      err_d = err_q;
      push  = 1'b0;
      if (stall) begin
         pc_d = pc_q;
      end else if (absJmp) begin
         pc_d = AluIn;
      end else if (relJmp) begin
         pc_d = pc_q + AluIn + WIDTH'(1);
      end else if (accept) begin
         push  = 1'b1;
         pc_d  = vec_addr;
         lvl_d = lvl_q + LW'(1);
         pri_d = cand;
         ack_d = NVEC'(1) << cand;
      end else if (reti && (lvl_q != '0)) begin
         pc_d  = stk_pc[rd_idx] + WIDTH'(1);
         pri_d = stk_pri[rd_idx];
         lvl_d = lvl_q - LW'(1);
      end else begin
         pc_d = pc_q + WIDTH'(1);
         if (reti) err_d = 1'b1;
      end
   end

   // Return stack storage; only reachable through lvl_q
   always_ff @(posedge clk) begin
      if (push) begin
         stk_pc[wr_idx]  <= pc_q;
         stk_pri[wr_idx] <= pri_q;
      end
   end

   // Architectural state with asynchronous reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= '0;
         lvl_q <= '0;
         pri_q <= PW'(NVEC);
         ack_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         lvl_q <= lvl_d;
         pri_q <= pri_d;
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end

   assign PC       = pc_q;
   assign Nextpc   = pc_q + WIDTH'(1);
   assign intrAck  = ack_q;
   assign inIsr    = (lvl_q != '0);
   assign level    = lvl_q;
   assign stackErr = err_q;

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, the PC and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the return-stack entries (maximum interrupt nesting), with DEPTH >= 1.
REQ-003 The block SHALL have parameter NVEC, default 4, the interrupt channels; channel 0 has the highest priority.
REQ-004 The block SHALL have parameter VEC_BASE, default 16'h0002, the vector address of channel 0.
REQ-005 The block SHALL have parameter VEC_STRIDE, default 2, the address spacing between consecutive vectors.

Interface
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 AluIn  in  WIDTH  jump target (absolute) or offset (relative, two's complement).
REQ-009 absJmp  in  1  absolute jump request.
REQ-010 relJmp  in  1  relative jump request.
REQ-011 stall  in  1  hold request: freezes all state.
REQ-012 intr  in  NVEC  level interrupt requests, one bit per channel.
REQ-013 reti  in  1  return-from-interrupt request.
REQ-014 PC  out  WIDTH  current program counter.
REQ-015 Nextpc  out  WIDTH  always PC+1 mod 2^WIDTH.
REQ-016 intrAck  out  NVEC  one-hot, one-cycle pulse marking the accepted channel.
REQ-017 inIsr  out  1  high while the nesting level is > 0.
REQ-018 level  out  clog2(DEPTH+1)  current nesting depth.
REQ-019 stackErr  out  1  sticky flag for return-stack underflow.

Function
REQ-020 Each unstalled cycle SHALL apply exactly one action; priority order is absJmp, relJmp, interrupt accept, reti, increment.
REQ-021 An absolute jump SHALL set PC to AluIn.
REQ-022 A relative jump SHALL set PC to PC+AluIn+1, truncated to WIDTH bits so it wraps modulo 2^WIDTH.
REQ-023 Increment SHALL set PC to PC+1, wrapping from all-ones to 0.
REQ-024 The current priority curPri SHALL be the channel of the top stack entry, or NVEC when level = 0.
REQ-025 The accept candidate SHALL be the lowest set index i of intr; it is accepted only if i < curPri and level < DEPTH.
REQ-026 On accept, the block SHALL push {PC, curPri}, set PC to VEC_BASE+i*VEC_STRIDE, increment level, and pulse intrAck[i] that cycle.
REQ-027 On reti with level > 0, the block SHALL pop, set PC to savedPC+1, restore curPri, and decrement level.
REQ-028 On reti with level = 0, the block SHALL set stackErr and treat the cycle as an increment.
REQ-029 A request that is not accepted (equal or lower priority, full stack, or masked by a jump) SHALL be ignored with no state change; the source must hold intr.
REQ-030 With stall high, PC, stack, level and stackErr SHALL hold, and intrAck SHALL be all zeros.
REQ-031 intrAck SHALL be registered and go high in the same cycle PC first shows the vector address.
REQ-032 Nextpc SHALL track PC combinationally or as a register, with no cycle of skew.

Reset
REQ-033 Asserting rst low SHALL asynchronously set PC=0, Nextpc=1, level=0, inIsr=0, intrAck=0, stackErr=0, curPri=NVEC.
REQ-034 Stack contents need no reset, but SHALL be unreachable at level 0.
REQ-035 Reset asserted mid-ISR SHALL abandon all nesting; the first edge after release SHALL give PC=1.
REQ-036 stackErr SHALL clear only on reset.

Verification
REQ-037 Reset release, no requests, 3 clocks -> PC 0,1,2,3; Nextpc = PC+1; level=0.
REQ-038 PC=16'h0010, relJmp, AluIn=16'hFFFD -> PC=16'h000E; then PC=16'hFFFF with increment -> PC=0, Nextpc=1.
REQ-039 PC=16'h0020, intr=4'b0100 -> PC=16'h0006, intrAck=4'b0100 for one cycle, level=1; intr=4'b1000 -> ignored; intr=4'b0001 -> PC=16'h0002, level=2; reti -> PC=16'h0007; reti -> PC=16'h0021, level=0.
REQ-040 With DEPTH=4, four nested accepts on channels 3,2,1,0 -> level=4; channel 0 reasserted -> ignored; absJmp with intr held -> jump taken, no intrAck.
REQ-041 reti at level 0 from PC=16'h0005 -> PC=16'h0006, stackErr=1, held until reset.
REQ-042 stall high for 2 cycles during an accept request -> PC and level unchanged, no intrAck; accept occurs on the first unstalled edge.
